// File: rtl/sram_patch_reader_pkg.sv
// rtl/sram_patch_reader_pkg.sv - shared image geometry, coordinate types and reader state enum
// Purpose: image dimensions, pixel/coordinate typedefs, reader FSM state type and
//          the packed FIFO entry used between the tag stage and the pixel output.
// Ports:   none (package).
package sram_patch_reader_pkg;

  localparam int PIXEL_DEPTH = 8;
  localparam int X_MAX       = 200;
  localparam int Y_MAX       = 200;
  localparam int XW          = $clog2(X_MAX);
  localparam int YW          = $clog2(Y_MAX);

  typedef logic [PIXEL_DEPTH-1:0] pixel_t;
  typedef logic [XW-1:0]          x_coord_t;
  typedef logic [YW-1:0]          y_coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  typedef struct packed {
    pixel_t data;
    logic   oob;
    logic   last;
  } fifo_entry_t;

endpackage

// File: rtl/sram_patch_reader_if.sv
// rtl/sram_patch_reader_if.sv - request, SRAM read port and pixel stream bundle for the patch reader
// Purpose: groups the request handshake, the SRAM read port and the pixel stream.
// Ports:   none; modport master is the reader side, modport slave is the environment
//          (request source, sram_image and the corner scorer).
interface sram_patch_reader_if;
  import sram_patch_reader_pkg::*;

  logic     req_valid;
  logic     req_ready;
  x_coord_t req_x;
  y_coord_t req_y;

  x_coord_t ram_x_addr;
  y_coord_t ram_y_addr;
  logic     ram_ren;
  logic     ram_wen;
  pixel_t   ram_rdat;

  logic     pix_valid;
  logic     pix_ready;
  pixel_t   pix_data;
  logic     pix_oob;
  logic     pix_last;

  logic     busy;

  modport master (
    input  req_valid, req_x, req_y, ram_rdat, pix_ready,
    output req_ready, ram_x_addr, ram_y_addr, ram_ren, ram_wen,
           pix_valid, pix_data, pix_oob, pix_last, busy
  );

  modport slave (
    output req_valid, req_x, req_y, ram_rdat, pix_ready,
    input  req_ready, ram_x_addr, ram_y_addr, ram_ren, ram_wen,
           pix_valid, pix_data, pix_oob, pix_last, busy
  );

endinterface

// File: rtl/sram_patch_reader_pix_fifo2.sv
// rtl/sram_patch_reader_pix_fifo2.sv - two-entry output FIFO for window pixels
// Purpose: 2-deep FIFO holding {data, oob, last}; head is always presented on rdata_o.
// Ports:   clk, n_rst (async active-low); push_i/wdata_i write side; pop_i read side;
//          rdata_o head entry; count_o occupancy 0..2.
module pix_fifo2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   count_q;

  // The issue credit upstream guarantees push only when a slot is free (or being
  // freed) and pop only when non-empty, so no full/empty guards are needed here.
  // A push never targets the head slot while the head is held, keeping it stable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) begin
        rptr_q <= ~rptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_patch_reader.sv
// rtl/sram_patch_reader.sv - fetches a (2R+1)^2 pixel window from sram_image and streams it out
// Purpose: on an accepted center request, walks the window in raster order, reads
//          in-image positions from the SRAM, substitutes BORDER_VAL for off-image ones
//          and streams pixels with oob/last flags.
// Ports:   clk, n_rst (async active-low); bus (master): req_* request handshake,
//          ram_* SRAM read port, pix_* pixel stream, busy.
module sram_patch_reader
  import sram_patch_reader_pkg::*;
#(
  parameter int RADIUS     = 3,
  parameter int BORDER_VAL = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  sram_patch_reader_if.master bus
);

  localparam int SPAN = 2 * RADIUS + 1;
  localparam int CW   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam logic [CW-1:0] IDX_MAX = CW'(SPAN - 1);

  reader_state_t state_q;
  x_coord_t      cx_q, ax_q;
  y_coord_t      cy_q, ay_q;
  logic [CW-1:0] ix_q, iy_q;
  logic          tag_v_q, tag_oob_q, tag_last_q;

  logic signed [XW:0] px;
  logic signed [YW:0] py;
  logic               oob, last_pos, issue, pop, ren, accept;
  logic [1:0]         fifo_count;
  logic [2:0]         occ;
  fifo_entry_t        head, fifo_wdata;

  // Window position = center + (index - RADIUS), one sign bit wider than the
  // coordinate so off-image positions on either side are representable.
  assign px = $signed({1'b0, cx_q}) + $signed((XW+1)'(ix_q)) - $signed((XW+1)'(RADIUS));
  assign py = $signed({1'b0, cy_q}) + $signed((YW+1)'(iy_q)) - $signed((YW+1)'(RADIUS));

  assign oob = px[XW] || (px >= $signed((XW+1)'(X_MAX)))
            || py[YW] || (py >= $signed((YW+1)'(Y_MAX)));
  assign last_pos = (ix_q == IDX_MAX) && (iy_q == IDX_MAX);

  assign pop = bus.pix_valid && bus.pix_ready;
  // Everything issued but not yet consumed (FIFO + tag stage) must fit in the
  // 2-entry FIFO, counting the slot freed by this cycle's pop.
  assign occ   = {1'b0, fifo_count} + {2'b00, tag_v_q};
  assign issue = (state_q == FETCH) && (occ < (3'd2 + {2'b00, pop}));
  assign ren   = issue && !oob;

  assign accept = bus.req_valid && bus.req_ready;

  // Off-image positions keep the previous address so the port never sees an
  // out-of-range coordinate.
  assign bus.ram_ren    = ren;
  assign bus.ram_wen    = 1'b0;
  assign bus.ram_x_addr = ren ? px[XW-1:0] : ax_q;
  assign bus.ram_y_addr = ren ? py[YW-1:0] : ay_q;

  assign bus.req_ready = (state_q == IDLE) && (fifo_count == 2'd0);
  assign bus.busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      ix_q       <= '0;
      iy_q       <= '0;
      tag_v_q    <= 1'b0;
      tag_oob_q  <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      // Tag stage lines up with the SRAM's one-cycle read latency.
      tag_v_q    <= issue;
      tag_oob_q  <= oob;
      tag_last_q <= last_pos;
      if (ren) begin
        ax_q <= px[XW-1:0];
        ay_q <= py[YW-1:0];
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            cx_q    <= bus.req_x;
            cy_q    <= bus.req_y;
            ix_q    <= '0;
            iy_q    <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (last_pos) begin
              ix_q    <= '0;
              iy_q    <= '0;
              state_q <= DRAIN;
            end else if (ix_q == IDX_MAX) begin
              ix_q <= '0;
              iy_q <= iy_q + 1'b1;
            end else begin
              ix_q <= ix_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wdata.data = tag_oob_q ? pixel_t'(BORDER_VAL) : bus.ram_rdat;
  assign fifo_wdata.oob  = tag_oob_q;
  assign fifo_wdata.last = tag_last_q;

  pix_fifo2 #(
    .W($bits(fifo_entry_t))
  ) u_pix_fifo2 (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (tag_v_q),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  assign bus.pix_valid = (fifo_count != 2'd0);
  assign bus.pix_data  = head.data;
  assign bus.pix_oob   = head.oob;
  assign bus.pix_last  = head.last;

endmodule

// File: tb/tb_sram_patch_reader.sv
// tb/tb_sram_patch_reader.sv - scoreboard bench for sram_patch_reader with a behavioural sram_image
module tb_sram_patch_reader;
  import sram_patch_reader_pkg::*;

  localparam int R = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       oob;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sram_patch_reader_if bus();

  sram_patch_reader #(.RADIUS(R), .BORDER_VAL(0)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, acc_cyc = 0, acc_cnt = 0, last_cnt = 0;
  int   ren_cnt = 0, win_beats = 0, first_cyc = 0;
  int   addr_bad = 0, ready_bad = 0;
  bit   want_first = 0, ready_mode = 0, prev_stall = 0;
  exp_t prev_out;
  bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [7:0] pixval(int x, int y);
    return 8'((x * 3 + y * 5 + 1) & 255);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_window(int cx, int cy);
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        exp_t e;
        int px, py;
        px     = cx + dx;
        py     = cy + dy;
        e.oob  = (px < 0) || (px >= 200) || (py < 0) || (py >= 200);
        e.data = e.oob ? 8'd0 : pixval(px, py);
        e.last = (dy == R) && (dx == R);
        exp_q.push_back(e);
      end
    end
  endtask

  // Behavioural sram_image: synchronous read, one-cycle latency.
  always @(posedge clk) begin
    cyc++;
    if (bus.ram_ren) bus.ram_rdat <= pixval(int'(bus.ram_x_addr), int'(bus.ram_y_addr));
  end

  initial begin
    int k = 0;
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        bus.pix_ready = pat[k % 6];
        k++;
      end else begin
        bus.pix_ready = 1'b1;
      end
    end
  end

  // Monitor: acceptance pushes the expected window; each pixel handshake pops one.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 0;
    end else begin
      exp_t cur;
      cur = {bus.pix_data, bus.pix_oob, bus.pix_last};
      if (bus.ram_ren) begin
        ren_cnt++;
        if (bus.ram_x_addr >= 8'd200 || bus.ram_y_addr >= 8'd200) addr_bad++;
      end
      if (bus.busy && bus.req_ready) ready_bad++;
      if (prev_stall && bus.pix_valid) check("stall_stable", int'(cur), int'(prev_out));
      if (want_first && bus.pix_valid) begin
        check("first_latency", cyc - acc_cyc, 2);
        want_first = 0;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        win_beats++;
        if (win_beats == 1) first_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(cur), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", int'(cur.data), int'(e.data));
          check("beat_oob", int'(cur.oob), int'(e.oob));
          check("beat_last", int'(cur.last), int'(e.last));
          if (e.last) begin
            last_cnt++;
            if (!ready_mode) check("back_to_back", cyc - first_cyc, 48);
          end
        end
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_out   = cur;
      if (bus.req_valid && bus.req_ready) begin
        push_window(int'(bus.req_x), int'(bus.req_y));
        acc_cyc    = cyc + 1;
        acc_cnt++;
        want_first = 1;
        win_beats  = 0;
        ren_cnt    = 0;
      end
    end
  end

  task automatic wait_done(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && exp_q.size() == 0) return;
    end
    check("window_timeout", 0, 1);
  endtask

  task automatic request(int x, int y);
    int a0;
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.req_x     = x[7:0];
    bus.req_y     = y[7:0];
    bus.req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != a0) break;
    end
    bus.req_valid = 1'b0;
    if (acc_cnt == a0) check("accept_timeout", 0, 1);
  endtask

  task automatic run(int x, int y, int exp_ren);
    request(x, y);
    wait_done(400);
    check("ren_count", ren_cnt, exp_ren);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int a0, l0;
    n_rst         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pix_valid", int'(bus.pix_valid), 0);
    check("rst_ram_ren", int'(bus.ram_ren), 0);
    check("rst_ram_wen", int'(bus.ram_wen), 0);
    check("rst_ram_x", int'(bus.ram_x_addr), 0);
    check("rst_pix_data", int'(bus.pix_data), 0);
    check("rst_pix_last", int'(bus.pix_last), 0);
    @(negedge clk);
    n_rst = 1'b1;

    run(100, 100, 49);
    run(0, 0, 16);
    run(199, 199, 16);
    ready_mode = 1;
    run(50, 20, 49);
    ready_mode = 0;

    a0 = acc_cnt;
    l0 = last_cnt;
    @(posedge clk);
    #1;
    bus.req_x     = 8'd30;
    bus.req_y     = 8'd40;
    bus.req_valid = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_done(400);
    check("accepts_eq_windows", acc_cnt - a0, last_cnt - l0);
    check("accepts_min", int'((acc_cnt - a0) >= 3), 1);

    l0 = last_cnt;
    request(60, 60);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (win_beats >= 10) break;
    end
    n_rst = 1'b0;
    #1;
    check("mid_rst_pix_valid", int'(bus.pix_valid), 0);
    check("mid_rst_pix_last", int'(bus.pix_last), 0);
    check("mid_rst_pix_data", int'(bus.pix_data), 0);
    check("mid_rst_req_ready", int'(bus.req_ready), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_ram_ren", int'(bus.ram_ren), 0);
    exp_q.delete();
    want_first = 0;
    repeat (3) @(negedge clk);
    #2;
    n_rst = 1'b1;
    run(5, 5, 49);
    check("last_after_reset", last_cnt - l0, 1);

    check("addr_in_range", addr_bad, 0);
    check("ready_low_when_busy", ready_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
